// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor: a PHT of 2-bit counters indexed by PC XOR global history.
// Define GSHARE_PREDICTOR_STATS_EN to build the lookup/mispredict event counters.
module gshare_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [31:0]         req_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_prediction,
    input  logic                upd_outcome,
    output logic                ready,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] initIdx_q, initIdx_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [1:0]            pht_q [ENTRIES];

    logic [INDEX_BITS-1:0] lookupIdx;
    logic [INDEX_BITS-1:0] updIdx;
    logic [1:0]            updCounter;
    logic [1:0]            updCounterNext;
    logic                  lookupAccept;
    logic                  updAccept;
    logic                  mispredict;
    logic                  unusedPcBits;

    assign ready        = (state_q == READY);
    assign lookupIdx    = req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign updIdx       = upd_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(upd_ghr);
    assign lookupAccept = req_valid & ready;
    assign updAccept    = upd_valid & ready;
    assign mispredict   = updAccept & (upd_prediction != upd_outcome);
    assign pred_taken   = ready & pht_q[lookupIdx][1];
    assign pred_ghr     = ghr_q;
    assign updCounter   = pht_q[updIdx];
    assign unusedPcBits = ^{req_pc[31:INDEX_BITS+2], req_pc[1:0],
                            upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    always_comb begin
        state_d   = state_q;
        initIdx_d = initIdx_q;
        case (state_q)
            INIT: begin
                initIdx_d = initIdx_q + INDEX_BITS'(1);
                if (&initIdx_q) begin
                    state_d = READY;
                end
            end
            READY: state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // A resolved mispredict repairs history and wins over the wrong-path speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {upd_ghr[GHR_BITS-2:0], upd_outcome};
        end else if (lookupAccept) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        end
    end

    always_comb begin
        updCounterNext = updCounter;
        if (upd_outcome) begin
            if (updCounter != 2'b11) begin
                updCounterNext = updCounter + 2'd1;
            end
        end else begin
            if (updCounter != 2'b00) begin
                updCounterNext = updCounter - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            initIdx_q <= '0;
            ghr_q     <= '0;
        end else begin
            state_q   <= state_d;
            initIdx_q <= initIdx_d;
            ghr_q     <= ghr_d;
        end
    end

    // The PHT is not reset; the INIT sweep writes every entry to weakly not-taken instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                pht_q[initIdx_q] <= 2'b01;
            end else if (updAccept) begin
                pht_q[updIdx] <= updCounterNext;
            end
        end
    end

`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (lookupAccept) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (mispredict) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: table-driven vectors with a scoreboard queue.
// Covers init sweep timing, counter saturation, history shift/repair and mid-INIT reset.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_taken;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_prediction;
    logic        upd_outcome;
    logic        ready;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.INDEX_BITS(6), .GHR_BITS(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_pc           (req_pc),
        .pred_taken       (pred_taken),
        .pred_ghr         (pred_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_ghr          (upd_ghr),
        .upd_prediction   (upd_prediction),
        .upd_outcome      (upd_outcome),
        .ready            (ready),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic        reqValid;
        logic [31:0] reqPc;
        logic        updValid;
        logic [31:0] updPc;
        logic [5:0]  updGhr;
        logic        updPred;
        logic        updOut;
        logic        expTaken;
        logic [5:0]  expGhr;
    } vec_t;

    typedef struct {
        string      name;
        logic       expTaken;
        logic [5:0] expGhr;
        logic       expReady;
    } exp_t;

    exp_t sbQueue[$];
    vec_t table0[21];
    vec_t table1[8];
    int   numChecks = 0;
    int   numFails  = 0;

`ifdef GSHARE_PREDICTOR_STATS_EN
    localparam logic [31:0] EXP_LOOKUPS     = 32'd5;
    localparam logic [31:0] EXP_MISPREDICTS = 32'd2;
`else
    localparam logic [31:0] EXP_LOOKUPS     = 32'd0;
    localparam logic [31:0] EXP_MISPREDICTS = 32'd0;
`endif

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic uv,
                                input logic [31:0] upc, input logic [5:0] ughr,
                                input logic up, input logic uo,
                                input logic et, input logic [5:0] eg);
        vec_t v;
        v.reqValid = rv;  v.reqPc  = rpc;  v.updValid = uv;  v.updPc = upc;
        v.updGhr   = ughr; v.updPred = up; v.updOut   = uo;
        v.expTaken = et;  v.expGhr = eg;
        return v;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
        numChecks++;
        if (act !== req) begin
            numFails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Drives one cycle of inputs (just after a posedge) and queues what must be seen this cycle.
    task automatic applyStimulus(input vec_t v, input string name, input logic expReady);
        exp_t e;
        rst_n          = 1'b1;
        req_valid      = v.reqValid;
        req_pc         = v.reqPc;
        upd_valid      = v.updValid;
        upd_pc         = v.updPc;
        upd_ghr        = v.updGhr;
        upd_prediction = v.updPred;
        upd_outcome    = v.updOut;
        e.name     = name;
        e.expTaken = v.expTaken;
        e.expGhr   = v.expGhr;
        e.expReady = expReady;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (sbQueue.size() == 0) begin
            compare("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            compare({e.name, "_ready"}, 32'(ready), 32'(e.expReady));
            compare({e.name, "_taken"}, 32'(pred_taken), 32'(e.expTaken));
            compare({e.name, "_ghr"}, 32'(pred_ghr), 32'(e.expGhr));
        end
    endtask

    task automatic runCycle(input vec_t v, input string name, input logic expReady);
        applyStimulus(v, name, expReady);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_ghr   = '0;
        upd_prediction = 1'b0;
        upd_outcome    = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Random traffic during INIT must leave history and table untouched and predict not-taken.
    task automatic runInit(input int cycles, input string name);
        vec_t v;
        for (int k = 0; k < cycles; k++) begin
            v = mk(1'($urandom), $urandom, 1'($urandom), $urandom, 6'($urandom),
                   1'($urandom), 1'($urandom), 1'b0, 6'h00);
            applyStimulus(v, $sformatf("%s_%0d", name, k), 1'b0);
            checkOutput();
            if (k == 0) begin
                compare({name, "_stat_lookups_clr"}, stat_lookups, 32'd0);
                compare({name, "_stat_mispredicts_clr"}, stat_mispredicts, 32'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Counter training on index 0x10, then history shift and repair.
        table0[0]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 1, 1, 0, 6'h00);
        table0[1]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 1, 1, 1, 6'h00);
        table0[2]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 1, 1, 1, 6'h00);
        table0[3]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 0, 0, 1, 6'h00);
        table0[4]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 0, 0, 1, 6'h00);
        table0[5]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 0, 0, 0, 6'h00);
        table0[6]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 0, 0, 0, 6'h00);
        table0[7]  = mk(0, 32'h40, 0, 32'h40,  6'h00, 0, 0, 0, 6'h00);
        table0[8]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 1, 1, 0, 6'h00);
        table0[9]  = mk(0, 32'h40, 1, 32'h40,  6'h00, 1, 1, 0, 6'h00);
        table0[10] = mk(0, 32'h40, 0, 32'h40,  6'h00, 0, 0, 1, 6'h00);
        table0[11] = mk(0, 32'h40, 1, 32'h40,  6'h01, 1, 1, 1, 6'h00);
        table0[12] = mk(0, 32'h40, 1, 32'h40,  6'h03, 1, 1, 1, 6'h00);
        table0[13] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 1, 6'h00);
        table0[14] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 1, 6'h01);
        table0[15] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 1, 6'h03);
        table0[16] = mk(0, 32'h40, 0, 32'h0,   6'h00, 0, 0, 0, 6'h07);
        table0[17] = mk(1, 32'h40, 1, 32'h100, 6'h05, 1, 0, 0, 6'h07);
        table0[18] = mk(1, 32'h40, 1, 32'h40,  6'h10, 1, 1, 0, 6'h0A);
        table0[19] = mk(0, 32'h0,  0, 32'h0,   6'h00, 0, 0, 0, 6'h14);
        table0[20] = mk(0, 32'h50, 0, 32'h0,   6'h00, 0, 0, 1, 6'h14);

        // Post-reset traffic: 5 accepted lookups, 2 mispredicting updates.
        table1[0] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 0, 6'h00);
        table1[1] = mk(1, 32'h80, 1, 32'h200, 6'h03, 1, 0, 0, 6'h00);
        table1[2] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 0, 6'h06);
        table1[3] = mk(0, 32'h40, 1, 32'h40,  6'h00, 0, 1, 0, 6'h0C);
        table1[4] = mk(1, 32'h40, 0, 32'h0,   6'h00, 0, 0, 0, 6'h01);
        table1[5] = mk(1, 32'h44, 0, 32'h0,   6'h00, 0, 0, 0, 6'h02);
        table1[6] = mk(0, 32'h40, 0, 32'h0,   6'h00, 0, 0, 0, 6'h04);
        table1[7] = mk(0, 32'h50, 0, 32'h0,   6'h00, 0, 0, 1, 6'h04);

        doReset(2);
        runInit(64, "init");
        for (int i = 0; i < 21; i++) begin
            runCycle(table0[i], $sformatf("t0_row%0d", i), 1'b1);
        end

        $display("[TB] mid-INIT reset sequence");
        doReset(2);
        runInit(30, "init_partial");
        doReset(1);
        runInit(64, "init_restart");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table1[i], $sformatf("t1_row%0d", i), 1'b1);
            checkOutput();
            if (i == 6) begin
                compare("stat_lookups", stat_lookups, EXP_LOOKUPS);
                compare("stat_mispredicts", stat_mispredicts, EXP_MISPREDICTS);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6: PHT has 2^INDEX_BITS 2-bit saturating counters.
REQ-002 SHALL have parameter GHR_BITS, default 6 (must be <= INDEX_BITS): global history register (GHR) width.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1: decode-stage predict request (branch decoded).
REQ-006 SHALL have port req_pc  input  32: PC of the decoded branch.
REQ-007 SHALL have port pred_taken  output  1: prediction, 1 = TAKEN; combinational from req_pc and current GHR.
REQ-008 SHALL have port pred_ghr  output  GHR_BITS: GHR snapshot used for the prediction; carried to EX by the requester.
REQ-009 SHALL have port upd_valid  input  1: EX-stage resolved branch.
REQ-010 SHALL have port upd_pc  input  32: PC of the resolved branch.
REQ-011 SHALL have port upd_ghr  input  GHR_BITS: snapshot returned unchanged from pred_ghr.
REQ-012 SHALL have ports upd_prediction and upd_outcome, each input 1: predicted direction and actual direction (1 = taken).
REQ-013 SHALL have port ready  output  1: table initialised; 0 during INIT.
REQ-014 SHALL have ports stat_lookups and stat_mispredicts, each output 32: event counters (see Configuration).

Function
REQ-015 Index SHALL be pc[INDEX_BITS+1:2] XOR zero-extended GHR; the lookup index uses req_pc with the current GHR, the update index uses upd_pc with upd_ghr.
REQ-016 pred_taken SHALL be the MSB of the indexed counter when ready=1, else 0; pred_ghr SHALL equal the current GHR.
REQ-017 On req_valid & ready, with no mispredict update in the same cycle, GHR SHALL become {GHR[GHR_BITS-2:0], pred_taken} next cycle.
REQ-018 On upd_valid & ready, the counter at the update index SHALL increment if upd_outcome=1 and decrement otherwise, saturating at 3 and 0.
REQ-019 On upd_valid & ready & (upd_prediction != upd_outcome), GHR SHALL become {upd_ghr[GHR_BITS-2:0], upd_outcome}; this overrides a simultaneous REQ-017 shift, because that request is on the wrong path.
REQ-020 A same-cycle lookup and update of the same index SHALL return the pre-update counter value; the write is visible from the next cycle.
REQ-021 The FSM SHALL have states INIT and READY: INIT writes counter[i]=2'b01 (weakly not-taken) for i = 0 .. 2^INDEX_BITS-1, one entry per cycle, then moves to READY; READY is terminal until reset.
REQ-022 In INIT, requests and updates SHALL be ignored: no GHR or PHT change, pred_taken=0.

Reset
REQ-023 While rst_n=0 at posedge clk: FSM=INIT, init counter=0, GHR=0, stat counters=0, ready=0.
REQ-024 Reset asserted mid-operation, including mid-INIT, SHALL restart the full INIT sweep from entry 0.
REQ-025 ready SHALL rise exactly 2^INDEX_BITS cycles after the first posedge with rst_n=1.

Configuration
REQ-026 With macro GSHARE_PREDICTOR_STATS_EN defined: stat_lookups increments on each accepted req_valid (REQ-017 condition, ignoring override); stat_mispredicts increments on each update meeting the REQ-019 condition; both wrap at 2^32.
REQ-027 Without GSHARE_PREDICTOR_STATS_EN: both stat outputs are tied to 0 and no counter registers exist.

Verification
REQ-028 Reset, INDEX_BITS=6 -> ready=0 for 64 cycles, then 1; every lookup during INIT gives pred_taken=0.
REQ-029 After init, pc=0x40, GHR=0: 2 updates taken -> counter 01->10->11; a lookup with pc=0x40 and GHR=0 gives pred_taken=1; a third taken update keeps the counter at 11.
REQ-030 GHR=0, req_valid with prediction 1 for 3 consecutive cycles -> pred_ghr sequence 0x00, 0x01, 0x03; final GHR 0x07.
REQ-031 Same-cycle req_valid and mispredict update with upd_ghr=0x05, upd_outcome=0 -> next GHR=0x0A, not the speculative shift.
REQ-032 Same-cycle lookup and update to the same index, counter=01, outcome taken -> pred_taken=0 that cycle and 1 the next cycle.
REQ-033 rst_n pulsed low at INIT entry 30 -> ready stays 0 for a fresh 64 cycles; with stats enabled, 5 lookups and 2 mispredicts -> stat_lookups=5, stat_mispredicts=2.
